// File: rtl/dma_mem_copier.sv
// dma_mem_copier: bus initiator that copies a block of words from one memory
// region to another. Each word is read and then written back.
// The memory bus is single-port, with a bidirectional data bus.
// Optional feature macro: DMA_RANGE_CHK_EN. When it is defined, a transfer that
// would run past MEM_DEPTH is rejected with err=1. The bus is never touched.
module dma_mem_copier #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MEM_DEPTH = 192,
  parameter int READ_LAT  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] words_done,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_FIN     = 3'd4;

  localparam int            LCW      = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LCW-1:0] LAT_LAST = LCW'(READ_LAT - 1);

  logic [2:0]     state;
  logic [LCW-1:0] lat_cnt;
  logic [AW-1:0]  src_q, dst_q, len_q;
  logic [DW-1:0]  wbuf;
  logic [AW-1:0]  wd_inc;
  logic           range_bad;

  assign wd_inc = words_done + 1'b1;

`ifdef DMA_RANGE_CHK_EN
  localparam logic [AW:0] DEPTH_L = (AW+1)'(MEM_DEPTH);
  logic [AW:0] src_end, dst_end;
  // End addresses are taken one bit wider, so a block that runs past the top is caught and does not wrap
  assign src_end   = {1'b0, src_addr} + {1'b0, len};
  assign dst_end   = {1'b0, dst_addr} + {1'b0, len};
  assign range_bad = (src_end > DEPTH_L) || (dst_end > DEPTH_L);
`else
  assign range_bad = 1'b0;
`endif

  // The data bus is driven only from the same flop as mem_wr, so the memory and this block never drive it together
  assign mem_data = mem_wr ? wbuf : {DW{1'bz}};

  // Control FSM: all outputs are registered. Reset stops any transfer at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      words_done <= '0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      lat_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          mem_wr <= 1'b0;
          if (start) begin
            busy       <= 1'b1;
            words_done <= '0;
            err        <= range_bad;
            if (len == '0 || range_bad) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state    <= S_RD;
              mem_addr <= src_addr;
            end
          end
        end
        S_RD: begin
          state   <= S_RD_WAIT;
          lat_cnt <= '0;
        end
        S_RD_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state    <= S_WR;
            mem_wr   <= 1'b1;
            mem_addr <= dst_q + words_done;
          end else begin
            lat_cnt <= lat_cnt + LCW'(1);
          end
        end
        S_WR: begin
          mem_wr     <= 1'b0;
          words_done <= wd_inc;
          if (wd_inc == len_q) begin
            state <= S_FIN;
            done  <= 1'b1;
          end else begin
            state    <= S_RD;
            mem_addr <= src_q + wd_inc;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

  // Data registers have no reset: they latch the block parameters and capture each read word
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      src_q <= src_addr;
      dst_q <= dst_addr;
      len_q <= len;
    end
    if (state == S_RD_WAIT && lat_cnt == LAT_LAST)
      wbuf <= mem_data;
  end

endmodule

// File: tb/tb_dma_mem_copier.sv
// tb_dma_mem_copier: directed bench for dma_mem_copier, using a 256-word memory model with one cycle of read latency.
module tb_dma_mem_copier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  src_addr, dst_addr, len;
  logic        busy, done, err;
  logic [7:0]  words_done;
  logic        mem_wr;
  logic [7:0]  mem_addr;
  wire  [31:0] mem_data;

  logic [31:0] mem [256];
  logic [31:0] rdata;
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  int n_checks = 0;
  int n_fail   = 0;

  int   dcyc, pulses, writes, wr_seen;
  logic busy_after;

  always #5 clk = ~clk;

  dma_mem_copier dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
    .words_done(words_done), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data(mem_data)
  );

  // Memory model: a synchronous read (one cycle of latency), a write on mem_wr, and a back-door preload port
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_wr) mem[mem_addr] <= mem_data;
    rdata <= mem[mem_addr];
  end
  assign mem_data = (!mem_wr && rst_n) ? rdata : 32'bz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Start a copy and watch it. Cycle 0 is the cycle in which start is high.
  // inj > 0 raises a second start, with different arguments, in cycle inj.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input int inj, output int done_cyc, output int np,
                          output int nw, output logic b_after);
    done_cyc = -1; np = 0; nw = 0; b_after = 1'bx;
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (inj > 0 && cyc == inj) begin
        start = 1'b1; src_addr = 8'd1; dst_addr = 8'd50; len = 8'd5;
      end
      if (inj > 0 && cyc == inj + 1) start = 1'b0;
      if (mem_wr) nw++;
      if (done) begin
        np++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) b_after = busy;
      if (done_cyc >= 0 && cyc == done_cyc + 3) break;
    end
    start = 1'b0;
    if (done_cyc < 0) chk("timeout_done", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_words_done", words_done, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;

    preload(8'd1, 32'd8); preload(8'd2, 32'd9); preload(8'd3, 32'd12);
    preload(8'd10, 32'hDEAD0010); preload(8'd11, 32'hDEAD0011);
    preload(8'd50, 32'h5050);
    preload(8'd30, 32'h30A); preload(8'd31, 32'h31B);

    // Reset during the second write cycle of a 4-word copy
    @(negedge clk);
    src_addr = 8'd1; dst_addr = 8'd10; len = 8'd4; start = 1'b1;
    wr_seen = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (mem_wr) wr_seen++;
      if (wr_seen == 2) break;
    end
    chk("midrst_reached_wr2", wr_seen, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_wr", mem_wr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_words_done", words_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_first_word", mem[10], 32'd8);
    chk("midrst_no_partial", mem[11], 32'hDEAD0011);

    // Basic copy of three words
    run_copy(8'd1, 8'd20, 8'd3, 0, dcyc, pulses, writes, busy_after);
    chk("basic_m20", mem[20], 32'd8);
    chk("basic_m21", mem[21], 32'd9);
    chk("basic_m22", mem[22], 32'd12);
    chk("basic_done_cyc", dcyc, 10);
    chk("basic_pulses", pulses, 1);
    chk("basic_writes", writes, 3);
    chk("basic_words_done", words_done, 3);
    chk("basic_err", err, 0);
    chk("basic_idle", busy_after, 0);

    // A zero-length transfer
    run_copy(8'd5, 8'd6, 8'd0, 0, dcyc, pulses, writes, busy_after);
    chk("len0_done_cyc", dcyc, 1);
    chk("len0_writes", writes, 0);
    chk("len0_words_done", words_done, 0);
    chk("len0_pulses", pulses, 1);

    // A second start while busy is ignored
    run_copy(8'd30, 8'd40, 8'd2, 3, dcyc, pulses, writes, busy_after);
    chk("busy_m40", mem[40], 32'h30A);
    chk("busy_m41", mem[41], 32'h31B);
    chk("busy_pulses", pulses, 1);
    chk("busy_done_cyc", dcyc, 7);
    chk("busy_words_done", words_done, 2);
    chk("busy_m50_untouched", mem[50], 32'h5050);

    // A start during FIN is ignored
    run_copy(8'd30, 8'd60, 8'd1, 4, dcyc, pulses, writes, busy_after);
    chk("fin_done_cyc", dcyc, 4);
    chk("fin_start_ignored", busy_after, 0);
    chk("fin_m60", mem[60], 32'h30A);

    // An overlapping forward copy
    preload(8'd0, 32'hA); preload(8'd1, 32'hB); preload(8'd2, 32'hC);
    run_copy(8'd0, 8'd1, 8'd2, 0, dcyc, pulses, writes, busy_after);
    chk("ovl_m1", mem[1], 32'hA);
    chk("ovl_m2", mem[2], 32'hA);

    preload(8'd190, 32'h190); preload(8'd191, 32'h191); preload(8'd192, 32'h192);
`ifdef DMA_RANGE_CHK_EN
    run_copy(8'd190, 8'd0, 8'd3, 0, dcyc, pulses, writes, busy_after);
    chk("rng_err", err, 1);
    chk("rng_done_cyc", dcyc, 1);
    chk("rng_writes", writes, 0);
    chk("rng_m0_untouched", mem[0], 32'hA);
    @(negedge clk);
    chk("rng_err_held", err, 1);
`else
    // An address wrap: 254, 255, 0
    preload(8'd254, 32'hE); preload(8'd255, 32'hF);
    run_copy(8'd254, 8'd100, 8'd3, 0, dcyc, pulses, writes, busy_after);
    chk("wrap_m100", mem[100], 32'hE);
    chk("wrap_m101", mem[101], 32'hF);
    chk("wrap_m102", mem[102], 32'hA);
    run_copy(8'd190, 8'd0, 8'd3, 0, dcyc, pulses, writes, busy_after);
    chk("norng_err", err, 0);
    chk("norng_writes", writes, 3);
    chk("norng_m0", mem[0], 32'h190);
    chk("norng_m2", mem[2], 32'h192);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
